// File: rtl/zed_uart_mmio.sv
// zed_uart_mmio: memory-mapped 8N1 UART with TX/RX FIFOs, 16x baud divisor and sticky error flags.
// Optional level interrupt and its enables are built only when UART_IRQ_EN is defined.
module zed_uart_mmio #(
    parameter int          TX_DEPTH_LOG2 = 4,
    parameter int          RX_DEPTH_LOG2 = 4,
    parameter logic [15:0] DEFAULT_DIV   = 16'd40
) (
    input  logic       clk_720p,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       rx,
    output logic       tx,
    output logic       irq
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;
    localparam int TL = TX_DEPTH_LOG2;
    localparam int RL = RX_DEPTH_LOG2;

    logic wr_data, wr_stat, wr_dlo, wr_dhi, rd_data;
    assign wr_data = cs & we & (addr == 2'd0);
    assign wr_stat = cs & we & (addr == 2'd1);
    assign wr_dlo  = cs & we & (addr == 2'd2);
    assign wr_dhi  = cs & we & (addr == 2'd3);
    assign rd_data = cs & !we & (addr == 2'd0);

    logic [15:0] div_q, bcnt_q, div_m1;
    logic        tick;
    assign div_m1 = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
    assign tick   = bcnt_q == div_m1;

    always_ff @(posedge clk_720p or posedge reset) begin
        if (reset) begin
            div_q  <= DEFAULT_DIV;
            bcnt_q <= 16'd0;
        end else begin
            div_q  <= wr_dlo ? {div_q[15:8], wdata} : wr_dhi ? {wdata, div_q[7:0]} : div_q;
            bcnt_q <= (wr_dlo | wr_dhi | tick) ? 16'd0 : bcnt_q + 16'd1;
        end
    end

    logic [7:0]  tx_mem [1 << TL];
    logic [TL:0] tx_wp_q, tx_rp_q;
    logic        tx_empty, tx_full, tx_push, tx_pop, tx_idle;
    logic [7:0]  tx_head;
    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[TL] != tx_rp_q[TL]) && (tx_wp_q[TL-1:0] == tx_rp_q[TL-1:0]);
    assign tx_push  = wr_data & !tx_full;
    assign tx_head  = tx_mem[tx_rp_q[TL-1:0]];

    always_ff @(posedge clk_720p) begin
        if (tx_push) tx_mem[tx_wp_q[TL-1:0]] <= wdata;
    end

    logic [1:0] tx_st_q, tx_st_d;
    logic [3:0] tx_tk_q, tx_tk_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;

    // End of a stop bit reloads straight into START so consecutive bytes leave no gap.
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_tk_d  = tx_tk_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        if (tick) begin
            tx_tk_d = (tx_st_q == S_IDLE) ? 4'd0 : tx_tk_q + 4'd1;
            if (tx_st_q == S_IDLE || (tx_st_q == S_STOP && tx_tk_q == 4'hf)) begin
                tx_st_d = tx_empty ? S_IDLE : S_START;
                tx_pop  = !tx_empty;
                tx_sh_d = tx_empty ? tx_sh_q : tx_head;
            end else if (tx_tk_q == 4'hf) begin
                tx_st_d  = (tx_st_q == S_START) ? S_DATA : (tx_bit_q == 3'd7) ? S_STOP : S_DATA;
                tx_bit_d = (tx_st_q == S_START) ? 3'd0 : tx_bit_q + 3'd1;
                tx_sh_d  = (tx_st_q == S_START) ? tx_sh_q : {1'b0, tx_sh_q[7:1]};
            end
        end
    end

    assign tx      = (tx_st_q == S_START) ? 1'b0 : (tx_st_q == S_DATA) ? tx_sh_q[0] : 1'b1;
    assign tx_idle = tx_empty & (tx_st_q == S_IDLE);

    logic [7:0]  rx_mem [1 << RL];
    logic [RL:0] rx_wp_q, rx_rp_q;
    logic        rx_empty, rx_full, rx_push, rx_pop, rx_req, ferr_set, ovr_set;
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[RL] != rx_rp_q[RL]) && (rx_wp_q[RL-1:0] == rx_rp_q[RL-1:0]);
    assign rx_push  = rx_req & !rx_full;
    assign ovr_set  = rx_req & rx_full;
    assign rx_pop   = rd_data & !rx_empty;

    logic [2:0] rx_sync_q;
    logic       rx_in, rx_fall;
    assign rx_in   = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & !rx_sync_q[1];

    logic [1:0] rx_st_q, rx_st_d;
    logic [3:0] rx_tk_q, rx_tk_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;

    always_ff @(posedge clk_720p) begin
        if (rx_push) rx_mem[rx_wp_q[RL-1:0]] <= rx_sh_q;
    end

    // START counts 8 ticks to mid-bit, then every later sample lands 16 ticks on.
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_tk_d  = rx_tk_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_req   = 1'b0;
        ferr_set = 1'b0;
        if (rx_st_q == S_IDLE) begin
            rx_st_d = rx_fall ? S_START : S_IDLE;
            rx_tk_d = 4'd0;
        end else if (tick) begin
            rx_tk_d = rx_tk_q + 4'd1;
            if (rx_st_q == S_START && rx_tk_q == 4'd7) begin
                rx_st_d  = rx_in ? S_IDLE : S_DATA;
                rx_tk_d  = 4'd0;
                rx_bit_d = 3'd0;
            end else if (rx_st_q == S_DATA && rx_tk_q == 4'hf) begin
                rx_sh_d  = {rx_in, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                rx_st_d  = (rx_bit_q == 3'd7) ? S_STOP : S_DATA;
            end else if (rx_st_q == S_STOP && rx_tk_q == 4'hf) begin
                rx_st_d  = S_IDLE;
                rx_req   = rx_in;
                ferr_set = !rx_in;
            end
        end
    end

    logic ovr_q, ferr_q, irq_bit;
    logic [7:0] stat;
    assign stat = {irq_bit, 1'b0, ferr_q, ovr_q, rx_full, rx_empty, tx_idle, tx_full};

    always_ff @(posedge clk_720p or posedge reset) begin
        if (reset) begin
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_st_q   <= S_IDLE;
            tx_tk_q   <= 4'd0;
            tx_bit_q  <= 3'd0;
            tx_sh_q   <= 8'd0;
            rx_st_q   <= S_IDLE;
            rx_tk_q   <= 4'd0;
            rx_bit_q  <= 3'd0;
            rx_sh_q   <= 8'd0;
            rx_sync_q <= 3'b111;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            rdata     <= 8'd0;
        end else begin
            tx_wp_q   <= tx_wp_q + {{TL{1'b0}}, tx_push};
            tx_rp_q   <= tx_rp_q + {{TL{1'b0}}, tx_pop};
            rx_wp_q   <= rx_wp_q + {{RL{1'b0}}, rx_push};
            rx_rp_q   <= rx_rp_q + {{RL{1'b0}}, rx_pop};
            tx_st_q   <= tx_st_d;
            tx_tk_q   <= tx_tk_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            rx_st_q   <= rx_st_d;
            rx_tk_q   <= rx_tk_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_sync_q <= {rx_sync_q[1:0], rx};
            ovr_q     <= ovr_set | (ovr_q & !(wr_stat & wdata[4]));
            ferr_q    <= ferr_set | (ferr_q & !(wr_stat & wdata[5]));
            if (cs & !we)
                rdata <= (addr == 2'd0) ? (rx_empty ? 8'd0 : rx_mem[rx_rp_q[RL-1:0]]) :
                         (addr == 2'd1) ? stat : (addr == 2'd2) ? div_q[7:0] : div_q[15:8];
        end
    end

`ifdef UART_IRQ_EN
    logic ie_rx_q, ie_tx_q, irq_q;
    always_ff @(posedge clk_720p or posedge reset) begin
        if (reset) begin
            ie_rx_q <= 1'b0;
            ie_tx_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_stat) {ie_tx_q, ie_rx_q} <= wdata[1:0];
            irq_q <= (!rx_empty & ie_rx_q) | (tx_idle & ie_tx_q) | ovr_q | ferr_q;
        end
    end
    assign irq_bit = irq_q;
`else
    assign irq_bit = 1'b0;
`endif
    assign irq = irq_bit;
endmodule

// File: tb/tb_zed_uart_mmio.sv
// tb_zed_uart_mmio: directed bench for zed_uart_mmio covering registers, TX framing, RX, errors and reset.
module tb_zed_uart_mmio;
    logic       clk_720p = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       tx, irq, rx;
    logic       rx_drv = 1'b1;
    logic       loop = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] v;
    logic [7:0] exp_b;
    int         n;
`ifdef UART_IRQ_EN
    localparam logic [7:0] IRQ_B = 8'h80;
`else
    localparam logic [7:0] IRQ_B = 8'h00;
`endif

    assign rx = loop ? tx : rx_drv;
    always #5 clk_720p = ~clk_720p;

    zed_uart_mmio dut (
        .clk_720p(clk_720p), .reset(reset), .cs(cs), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk_720p);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk_720p);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk_720p);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk_720p);
        cs = 1'b0;
        d = rdata;
    endtask

    // One 8N1 frame at div=4 (64 clocks per bit), driven from negedges.
    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        rx_drv = 1'b0;
        repeat (64) @(negedge clk_720p);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (64) @(negedge clk_720p);
        end
        rx_drv = stop_b;
        repeat (64) @(negedge clk_720p);
        rx_drv = 1'b1;
    endtask

    task automatic wait_tx_low(output int cnt);
        cnt = 0;
        while (tx !== 1'b0 && cnt < 200) begin
            @(negedge clk_720p);
            cnt++;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk_720p);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_tx", {7'd0, tx}, 8'h01);
        chk("rst_irq", {7'd0, irq}, 8'h00);
        reset = 1'b0;
        rd(2'd1, v); chk("rst_stat", v, 8'h06);
        rd(2'd2, v); chk("rst_divlo", v, 8'd40);
        rd(2'd3, v); chk("rst_divhi", v, 8'd0);

        wr(2'd2, 8'd4);
        rd(2'd2, v); chk("divlo_wr", v, 8'd4);
        wr(2'd0, 8'hA5);
        wait_tx_low(n);
        chk("tx_start_seen", {7'd0, n < 200}, 8'h01);
        rd(2'd1, v); chk("stat_busy", v, 8'h04);
        repeat (30) @(negedge clk_720p);
        chk("tx_start_bit", {7'd0, tx}, 8'h00);
        exp_b = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            repeat (64) @(negedge clk_720p);
            chk($sformatf("tx_bit%0d", i), {7'd0, tx}, {7'd0, exp_b[i]});
        end
        repeat (64) @(negedge clk_720p);
        chk("tx_stop_bit", {7'd0, tx}, 8'h01);
        repeat (40) @(negedge clk_720p);
        rd(2'd1, v); chk("stat_tx_done", v, 8'h06);

        loop = 1'b1;
        wr(2'd0, 8'h00);
        wr(2'd0, 8'hFF);
        wr(2'd0, 8'h3C);
        repeat (2200) @(negedge clk_720p);
        rd(2'd0, v); chk("loop_b0", v, 8'h00);
        rd(2'd0, v); chk("loop_b1", v, 8'hFF);
        rd(2'd0, v); chk("loop_b2", v, 8'h3C);
        rd(2'd1, v); chk("loop_stat", v, 8'h06);
        rd(2'd0, v); chk("empty_read", v, 8'h00);
        loop = 1'b0;
        repeat (10) @(negedge clk_720p);

        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1);
        repeat (10) @(negedge clk_720p);
        rd(2'd1, v); chk("ovr_stat", v, 8'h1A | IRQ_B);
        for (int i = 0; i < 16; i++) begin
            rd(2'd0, v);
            chk($sformatf("ovr_b%0d", i), v, 8'h10 + 8'(i));
        end
        rd(2'd1, v); chk("ovr_drained", v, 8'h16 | IRQ_B);
        wr(2'd1, 8'h10);
        repeat (2) @(negedge clk_720p);
        rd(2'd1, v); chk("ovr_clear", v, 8'h06);

        send_frame(8'hC3, 1'b0);
        repeat (10) @(negedge clk_720p);
        rd(2'd1, v); chk("ferr_stat", v, 8'h26 | IRQ_B);
        wr(2'd1, 8'h20);
        repeat (2) @(negedge clk_720p);
        rd(2'd1, v); chk("ferr_clear", v, 8'h06);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk_720p);
        rx_drv = 1'b1;
        repeat (800) @(negedge clk_720p);
        rd(2'd1, v); chk("glitch_stat", v, 8'h06);

        wr(2'd1, 8'h01);
        send_frame(8'h5A, 1'b1);
        repeat (5) @(negedge clk_720p);
        chk("irq_rx", {7'd0, irq}, {7'd0, IRQ_B[7]});
        rd(2'd1, v); chk("irq_stat", v, 8'h02 | IRQ_B);
        rd(2'd0, v); chk("irq_byte", v, 8'h5A);
        @(negedge clk_720p);
        chk("irq_pop", {7'd0, irq}, 8'h00);

        wr(2'd0, 8'h55);
        wait_tx_low(n);
        chk("rst_tx_start", {7'd0, n < 200}, 8'h01);
        repeat (10) @(negedge clk_720p);
        chk("mid_tx_low", {7'd0, tx}, 8'h00);
        reset = 1'b1;
        #1;
        chk("async_tx_high", {7'd0, tx}, 8'h01);
        repeat (2) @(negedge clk_720p);
        reset = 1'b0;
        rd(2'd1, v); chk("rst2_stat", v, 8'h06);
        rd(2'd2, v); chk("rst2_divlo", v, 8'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
